i2c_edge_interval_checker: RTL and testbench

//   Clocked timing monitor for I2C SCL/SDA relations (tHD;STA, tLOW, tHD;DAT, tSU;DAT, tHIGH, tSU;STA, tSU;STO).

---
 rtl/i2c_chk_pkg.sv | 22 ++
 rtl/sig_edge_det.sv | 34 +++
 rtl/i2c_edge_interval_checker.sv | 100 ++++++++++
 tb/tb_i2c_edge_interval_checker.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/i2c_chk_pkg.sv
// i2c_chk_pkg: edge-mode encodings and the edge-qualification function
//   shared by the interval checker and its edge detectors.
`default_nettype none

package i2c_chk_pkg;

  localparam logic [1:0] EDGE_RISE = 2'd0;
  localparam logic [1:0] EDGE_FALL = 2'd1;
  localparam logic [1:0] EDGE_ANY  = 2'd2;

  // The unused encoding 2'd3 behaves as EDGE_ANY.
  function automatic logic ev(input logic prev, input logic cur, input logic [1:0] mode);
    case (mode)
      EDGE_RISE: return !prev && cur;
      EDGE_FALL: return prev && !cur;
      default:   return prev ^ cur;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/sig_edge_det.sv
// sig_edge_det: single-signal edge detector. ev is asserted in the same
//   cycle as the qualifying change on d.
`default_nettype none

module sig_edge_det
  import i2c_chk_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       d,
  input  logic [1:0] mode,
  output logic       ev
);

  logic prev;
  logic primed;

  // The history register keeps sampling while reset is asserted, so it
  // holds the live value of d when reset is released.
  always_ff @(posedge clk) begin
    prev <= d;
  end

  // primed blocks the first cycle after release, before history is valid.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) primed <= 1'b0;
    else      primed <= 1'b1;
  end

  assign ev = primed && i2c_chk_pkg::ev(prev, d, mode);

endmodule

`default_nettype wire

// File: rtl/i2c_edge_interval_checker.sv
// i2c_edge_interval_checker: counts clk cycles from an s1 event to the next
//   s2 event and pulses vio when that interval is shorter than lim.
`default_nettype none

module i2c_edge_interval_checker
  import i2c_chk_pkg::*;
#(
  parameter logic [1:0] E1_MODE = EDGE_RISE,
  parameter logic [1:0] E2_MODE = EDGE_RISE,
  parameter int         CNT_W   = 32,
  parameter int         VIO_LEN = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s1,
  input  logic             s2,
  input  logic [CNT_W-1:0] lim,
  output logic             vio,
  output logic [15:0]      viol_cnt,
  output logic [CNT_W-1:0] last_delta
);

  localparam int               TMR_W    = $clog2(VIO_LEN + 1);
  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(VIO_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  logic             ev1;
  logic             ev2;
  logic             armed;
  logic [CNT_W-1:0] cnt;
  logic [TMR_W-1:0] vio_tmr;
  logic             viol;

  sig_edge_det u_det_s1 (
    .clk  (clk),
    .rst  (rst),
    .d    (s1),
    .mode (E1_MODE),
    .ev   (ev1)
  );

  sig_edge_det u_det_s2 (
    .clk  (clk),
    .rst  (rst),
    .d    (s2),
    .mode (E2_MODE),
    .ev   (ev2)
  );

  // Compare uses cnt before any same-cycle ev1 reload: the old interval.
  assign viol = ev2 && armed && (cnt < lim);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      armed <= 1'b0;
      cnt   <= '0;
    end else if (ev1) begin
      armed <= 1'b1;
      cnt   <= CNT_W'(1);
    end else if (armed && cnt != CNT_MAX) begin
      cnt   <= cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_delta <= '0;
    end else if (ev2 && armed) begin
      last_delta <= cnt;
    end
  end

  // vio_tmr holds the pulse cycles still owed after the current one;
  // a new violation reloads it so the pulse stretches.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vio     <= 1'b0;
      vio_tmr <= '0;
    end else if (viol) begin
      vio     <= 1'b1;
      vio_tmr <= TMR_LOAD;
    end else if (vio_tmr != '0) begin
      vio     <= 1'b1;
      vio_tmr <= vio_tmr - TMR_W'(1);
    end else begin
      vio     <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      viol_cnt <= '0;
    end else if (viol && viol_cnt != 16'hFFFF) begin
      viol_cnt <= viol_cnt + 16'd1;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_i2c_edge_interval_checker.sv
// tb_i2c_edge_interval_checker: directed checks of three checker variants
//   (RISE/RISE, RISE/ANY, and a narrow-counter RISE/RISE).
`default_nettype none

module tb_i2c_edge_interval_checker;
  import i2c_chk_pkg::*;

  logic        clk;
  logic        rst;

  logic        s1a, s2a;
  logic [31:0] lima;
  logic        vio_a;
  logic [15:0] vcnt_a;
  logic [31:0] delta_a;

  logic        s1b, s2b;
  logic [31:0] limb;
  logic        vio_b;
  logic [15:0] vcnt_b;
  logic [31:0] delta_b;

  logic        s1c, s2c;
  logic [3:0]  limc;
  logic        vio_c;
  logic [15:0] vcnt_c;
  logic [3:0]  delta_c;

  int n_chk = 0;
  int n_err = 0;

  i2c_edge_interval_checker #(.E1_MODE(EDGE_RISE), .E2_MODE(EDGE_RISE), .CNT_W(32), .VIO_LEN(2)) dut_a (
    .clk(clk), .rst(rst), .s1(s1a), .s2(s2a), .lim(lima),
    .vio(vio_a), .viol_cnt(vcnt_a), .last_delta(delta_a)
  );

  i2c_edge_interval_checker #(.E1_MODE(EDGE_RISE), .E2_MODE(EDGE_ANY), .CNT_W(32), .VIO_LEN(2)) dut_b (
    .clk(clk), .rst(rst), .s1(s1b), .s2(s2b), .lim(limb),
    .vio(vio_b), .viol_cnt(vcnt_b), .last_delta(delta_b)
  );

  i2c_edge_interval_checker #(.E1_MODE(EDGE_RISE), .E2_MODE(EDGE_RISE), .CNT_W(4), .VIO_LEN(1)) dut_c (
    .clk(clk), .rst(rst), .s1(s1c), .s2(s2c), .lim(limc),
    .vio(vio_c), .viol_cnt(vcnt_c), .last_delta(delta_c)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst  = 1'b1;
    s1a = 1'b0; s2a = 1'b0; lima = 32'd5;
    s1b = 1'b0; s2b = 1'b1; limb = 32'd4;
    s1c = 1'b0; s2c = 1'b0; limc = 4'd15;
    #2 rst = 1'b0;
    tick(2);
    check("rst_vio",   {31'd0, vio_a}, 32'd0);
    check("rst_vcnt",  {16'd0, vcnt_a}, 32'd0);
    check("rst_delta", delta_a, 32'd0);
    rst = 1'b1;
    tick(2);

    // s2 event before any s1 event: no check
    s2a = 1'b1; tick(2);
    check("noarm_vio",   {31'd0, vio_a}, 32'd0);
    check("noarm_delta", delta_a, 32'd0);
    s2a = 1'b0; tick;

    // interval 3 < 5
    s1a = 1'b1; tick(3);
    s2a = 1'b1; tick;
    check("short_vio",   {31'd0, vio_a}, 32'd1);
    check("short_delta", delta_a, 32'd3);
    check("short_vcnt",  {16'd0, vcnt_a}, 32'd1);
    tick; check("short_vio2", {31'd0, vio_a}, 32'd1);
    tick; check("short_vio3", {31'd0, vio_a}, 32'd0);

    // interval 6 >= 5
    s1a = 1'b0; s2a = 1'b0; tick;
    s1a = 1'b1; tick(6);
    s2a = 1'b1; tick;
    check("long_vio",   {31'd0, vio_a}, 32'd0);
    check("long_delta", delta_a, 32'd6);
    check("long_vcnt",  {16'd0, vcnt_a}, 32'd1);

    // interval equal to lim is legal
    s1a = 1'b0; s2a = 1'b0; tick;
    s1a = 1'b1; tick(5);
    s2a = 1'b1; tick;
    check("eq_vio",   {31'd0, vio_a}, 32'd0);
    check("eq_delta", delta_a, 32'd5);

    // lim = 0 never flags
    s1a = 1'b0; s2a = 1'b0; lima = 32'd0; tick;
    s1a = 1'b1; tick;
    s2a = 1'b1; tick;
    check("lim0_vio",   {31'd0, vio_a}, 32'd0);
    check("lim0_delta", delta_a, 32'd1);
    check("lim0_vcnt",  {16'd0, vcnt_a}, 32'd1);
    lima = 32'd5;

    // two violations two edges apart: pulse stretches
    s1a = 1'b0; s2a = 1'b0; tick;
    s1a = 1'b1; tick;
    s2a = 1'b1; tick;
    check("dbl_vio1", {31'd0, vio_a}, 32'd1);
    check("dbl_vcnt1", {16'd0, vcnt_a}, 32'd2);
    s2a = 1'b0; tick;
    check("dbl_vio2", {31'd0, vio_a}, 32'd1);
    s2a = 1'b1; tick;
    check("dbl_vio3",   {31'd0, vio_a}, 32'd1);
    check("dbl_delta",  delta_a, 32'd3);
    check("dbl_vcnt2",  {16'd0, vcnt_a}, 32'd3);
    tick; check("dbl_vio4", {31'd0, vio_a}, 32'd1);
    tick; check("dbl_vio5", {31'd0, vio_a}, 32'd0);

    // RISE/ANY: s2 falls 2 cycles after s1 rises
    s1b = 1'b1; tick(2);
    s2b = 1'b0; tick;
    check("any_vio",   {31'd0, vio_b}, 32'd1);
    check("any_delta", delta_b, 32'd2);
    check("any_vcnt",  {16'd0, vcnt_b}, 32'd1);
    s1b = 1'b0; tick(2);
    check("any_vio_end", {31'd0, vio_b}, 32'd0);
    // simultaneous ev1/ev2: old interval checked, then reload to 1
    s1b = 1'b1; s2b = 1'b1; tick;
    check("sim_delta", delta_b, 32'd5);
    check("sim_vio",   {31'd0, vio_b}, 32'd0);
    s2b = 1'b0; tick;
    check("reload_delta", delta_b, 32'd1);
    check("reload_vio",   {31'd0, vio_b}, 32'd1);
    check("reload_vcnt",  {16'd0, vcnt_b}, 32'd2);

    // 4-bit counter saturates at 15 instead of wrapping
    s1c = 1'b1; tick(21);
    s2c = 1'b1; tick;
    check("sat_delta", {28'd0, delta_c}, 32'd15);
    check("sat_vio",   {31'd0, vio_c}, 32'd0);
    s2c = 1'b0; tick(3);
    s2c = 1'b1; tick;
    check("sat_delta2", {28'd0, delta_c}, 32'd15);
    check("sat_vio2",   {31'd0, vio_c}, 32'd0);
    // VIO_LEN = 1 gives a single-cycle pulse
    s1c = 1'b0; tick;
    s1c = 1'b1; s2c = 1'b0; tick;
    s2c = 1'b1; tick;
    check("len1_vio",   {31'd0, vio_c}, 32'd1);
    check("len1_delta", {28'd0, delta_c}, 32'd1);
    check("len1_vcnt",  {16'd0, vcnt_c}, 32'd1);
    tick; check("len1_vio_end", {31'd0, vio_c}, 32'd0);

    // async reset while a vio pulse is active
    s1a = 1'b0; s2a = 1'b0; tick;
    s1a = 1'b1; tick;
    s2a = 1'b1; tick;
    check("pre_rst_vio", {31'd0, vio_a}, 32'd1);
    #2 rst = 1'b0;
    #1;
    check("arst_vio",   {31'd0, vio_a}, 32'd0);
    check("arst_vcnt",  {16'd0, vcnt_a}, 32'd0);
    check("arst_delta", delta_a, 32'd0);
    check("arst_vcnt_b", {16'd0, vcnt_b}, 32'd0);
    s1a = 1'b0; s2a = 1'b0; tick(2);
    rst = 1'b1; tick;
    s2a = 1'b1; tick;
    check("post_rst_vio",   {31'd0, vio_a}, 32'd0);
    check("post_rst_delta", delta_a, 32'd0);
    tick; check("post_rst_vio2", {31'd0, vio_a}, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
